ccff_chain_loader: RTL and testbench

//   Configuration-chain controller for a connection block. Serialises

---
 rtl/ccff_chain_loader.sv | 147 ++++++++++++++
 tb/tb_ccff_chain_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// Serialises configuration words into a connection block's ccff flip-flop chain,
// optionally checking the ones-count shifted out of the tail against the previous load.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 6
) (
  input  logic              prog_clk_i,
  input  logic              pReset_i,
  input  logic              start_i,
  input  logic              verify_en_i,
  input  logic [WORD_W-1:0] cfg_data_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  output logic              ccff_head_o,
  output logic              ccff_shift_en_o,
  input  logic              ccff_tail_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              verify_err_o
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_LOAD  | cfg_ready high, waiting for a word
  // S_SHIFT | one chain bit per cycle, nbits_q left in this word
  // S_DONE  | one-cycle done pulse, tail check resolved on exit
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t              state_q;
  logic [WORD_W-1:0]   sreg_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [CNT_W-1:0]    nbits_q;
  logic [CNT_W-1:0]    in_ones_q;
  logic [CNT_W-1:0]    tail_ones_q;
  logic [CNT_W-1:0]    prev_ones_q;
  logic                prev_valid_q;
  logic                verify_q;
  logic                cfg_ready_q;
  logic                shift_en_q;
  logic                head_q;
  logic                busy_q;
  logic                done_q;
  logic                verify_err_q;

  logic [CNT_W-1:0]    rem_bits;
  logic [CNT_W-1:0]    nbits_d;

  // The last word of a load may only partly fit; its upper bits never reach the chain.
  always_comb begin
    rem_bits = LEN_C - bit_cnt_q;
    nbits_d  = (rem_bits < WORD_C) ? rem_bits : WORD_C;
  end

  always_ff @(posedge prog_clk_i) begin
    if (pReset_i) begin
      state_q      <= S_IDLE;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      nbits_q      <= '0;
      in_ones_q    <= '0;
      tail_ones_q  <= '0;
      prev_ones_q  <= '0;
      prev_valid_q <= 1'b0;
      verify_q     <= 1'b0;
      cfg_ready_q  <= 1'b0;
      shift_en_q   <= 1'b0;
      head_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      verify_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q      <= S_LOAD;
            verify_q     <= verify_en_i;
            bit_cnt_q    <= '0;
            in_ones_q    <= '0;
            tail_ones_q  <= '0;
            verify_err_q <= 1'b0;
            busy_q       <= 1'b1;
            cfg_ready_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (cfg_valid_i) begin
            sreg_q      <= cfg_data_i;
            nbits_q     <= nbits_d;
            head_q      <= cfg_data_i[0];
            shift_en_q  <= 1'b1;
            cfg_ready_q <= 1'b0;
            state_q     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          sreg_q      <= sreg_q >> 1;
          head_q      <= sreg_q[1];
          bit_cnt_q   <= bit_cnt_q + ONE_C;
          nbits_q     <= nbits_q - ONE_C;
          in_ones_q   <= in_ones_q + {{(CNT_W-1){1'b0}}, sreg_q[0]};
          tail_ones_q <= tail_ones_q + {{(CNT_W-1){1'b0}}, ccff_tail_i};
          if (nbits_q == ONE_C) begin
            shift_en_q <= 1'b0;
            head_q     <= 1'b0;
            if (bit_cnt_q == LAST_C) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= S_LOAD;
              cfg_ready_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (verify_q && prev_valid_q) begin
            verify_err_q <= (tail_ones_q != prev_ones_q);
          end
          prev_ones_q  <= in_ones_q;
          prev_valid_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready_o     = cfg_ready_q;
  assign ccff_head_o     = head_q;
  assign ccff_shift_en_o = shift_en_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign verify_err_o    = verify_err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: drives loads into a shift-register chain model
// and checks shift counts, timing, bit order, tail verification and reset behaviour.
module tb_ccff_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start, ven, valid;
  logic [7:0] data;
  wire        tail;
  logic       ready, head, sen, busy, done, verr;

  logic       s_start, s_ven, s_valid, s_tail;
  logic [7:0] s_data;
  logic       s_ready, s_head, s_sen, s_busy, s_done, s_verr;

  logic [35:0] chain = '0;
  logic [5:0]  tap = 6'd35;
  assign tail = chain[tap];
  always @(posedge clk) if (sen === 1'b1) chain <= {chain[34:0], head};

  ccff_chain_loader #(.CHAIN_LEN(36), .WORD_W(8), .CNT_W(6)) u_dut (
    .prog_clk_i(clk), .pReset_i(rst), .start_i(start), .verify_en_i(ven),
    .cfg_data_i(data), .cfg_valid_i(valid), .cfg_ready_o(ready),
    .ccff_head_o(head), .ccff_shift_en_o(sen), .ccff_tail_i(tail),
    .busy_o(busy), .done_o(done), .verify_err_o(verr));

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(5)) u_small (
    .prog_clk_i(clk), .pReset_i(rst), .start_i(s_start), .verify_en_i(s_ven),
    .cfg_data_i(s_data), .cfg_valid_i(s_valid), .cfg_ready_o(s_ready),
    .ccff_head_o(s_head), .ccff_shift_en_o(s_sen), .ccff_tail_i(s_tail),
    .busy_o(s_busy), .done_o(s_done), .verify_err_o(s_verr));

  int checks = 0;
  int failures = 0;
  logic [7:0]  words [5];
  logic [35:0] head_seq;
  logic [35:0] exp_stream;
  logic [35:0] exp_chain;
  int sh_cnt, acc_cnt, done_cnt, done_rel, first_acc, stall_bad, stall_seen;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build_expected;
    for (int k = 0; k < 36; k++) begin
      exp_stream[k]    = words[k / 8][k % 8];
      exp_chain[35 - k] = words[k / 8][k % 8];
    end
  endtask

  task automatic run_load(input logic v, input int stall_after, input int stall_len,
                          input int start_pulse_at);
    int widx, stall_left, cyc, post;
    sh_cnt = 0; acc_cnt = 0; done_cnt = 0; done_rel = -1; first_acc = -1;
    stall_bad = 0; stall_seen = 0; head_seq = '0;
    widx = 0; stall_left = stall_len; cyc = 0; post = 0;
    start = 1'b1; ven = v;
    tick();
    start = 1'b0; ven = 1'b0;
    while (cyc < 300 && post < 4) begin
      if (widx == stall_after && stall_left > 0 && ready === 1'b1) begin
        valid = 1'b0;
        stall_left--;
        stall_seen++;
        if (sen !== 1'b0) stall_bad++;
      end else begin
        valid = (widx < 5);
      end
      data = (widx < 5) ? words[widx] : 8'h00;
      if (ready === 1'b1 && valid) begin
        if (first_acc < 0) first_acc = cyc;
        acc_cnt++;
        widx++;
      end
      if (sen === 1'b1) begin
        if (sh_cnt < 36) head_seq[sh_cnt] = head;
        sh_cnt++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_rel = cyc - first_acc;
      end
      start = (cyc == start_pulse_at);
      tick();
      cyc++;
      if (done_cnt > 0) post++;
    end
    valid = 1'b0; start = 1'b0;
    if (cyc >= 300) begin
      checks++; failures++;
      $display("FAIL load_timeout got cycles=%0d exp below 300", cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy, done, ready, sen, verr, head} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=000000", {busy, done, ready, sen, verr, head});
    end
    checks++;
    if ({s_busy, s_done, s_ready, s_sen, s_verr, s_head} !== 6'b0) begin
      failures++;
      $display("FAIL reset_small_outputs got=%b exp=000000",
               {s_busy, s_done, s_ready, s_sen, s_verr, s_head});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h09;
    build_expected();
    tap = 6'd35;
    run_load(1'b1, -1, 0, -1);
    checks++;
    if (sh_cnt != 36) begin failures++; $display("FAIL basic_shifts got=%0d exp=36", sh_cnt); end
    checks++;
    if (acc_cnt != 5) begin failures++; $display("FAIL basic_accepts got=%0d exp=5", acc_cnt); end
    checks++;
    if (done_cnt != 1 || done_rel != 41) begin
      failures++;
      $display("FAIL basic_done got count=%0d at=%0d exp count=1 at=41", done_cnt, done_rel);
    end
    checks++;
    if (head_seq !== exp_stream) begin
      failures++;
      $display("FAIL basic_head_seq got=%h exp=%h", head_seq, exp_stream);
    end
    checks++;
    if (head_seq[11:0] !== 12'b1100_1010_0101) begin
      failures++;
      $display("FAIL basic_head_first12 got=%b exp=110010100101", head_seq[11:0]);
    end
    checks++;
    if (chain !== exp_chain) begin
      failures++;
      $display("FAIL basic_chain_order got=%h exp=%h", chain, exp_chain);
    end
    checks++;
    if (verr !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_end_state got verr=%b busy=%b exp verr=0 busy=0", verr, busy);
    end
  endtask

  task automatic test_verify;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h09;
    tap = 6'd35;
    run_load(1'b1, -1, 0, -1);
    checks++;
    if (verr !== 1'b0) begin failures++; $display("FAIL verify_good_chain got=%b exp=0", verr); end
    // 35-bit chain: tail loses old bit0 (1) and gains new bit0 (0), so counts differ
    words[0] = 8'h5A; words[1] = 8'hC3; words[2] = 8'h00; words[3] = 8'hFF; words[4] = 8'h06;
    tap = 6'd34;
    run_load(1'b1, -1, 0, -1);
    checks++;
    if (verr !== 1'b1) begin failures++; $display("FAIL verify_short_chain got=%b exp=1", verr); end
    repeat (5) tick();
    checks++;
    if (verr !== 1'b1) begin failures++; $display("FAIL verify_err_hold got=%b exp=1", verr); end
    tap = 6'd35;
    run_load(1'b0, -1, 0, -1);
    checks++;
    if (verr !== 1'b0) begin failures++; $display("FAIL verify_err_clear got=%b exp=0", verr); end
  endtask

  task automatic test_stall;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h09;
    build_expected();
    run_load(1'b0, 2, 10, -1);
    checks++;
    if (stall_seen != 10 || stall_bad != 0) begin
      failures++;
      $display("FAIL stall_hold got stalled=%0d shifting=%0d exp stalled=10 shifting=0",
               stall_seen, stall_bad);
    end
    checks++;
    if (sh_cnt != 36) begin failures++; $display("FAIL stall_shifts got=%0d exp=36", sh_cnt); end
    checks++;
    if (done_cnt != 1 || done_rel != 51) begin
      failures++;
      $display("FAIL stall_done got count=%0d at=%0d exp count=1 at=51", done_cnt, done_rel);
    end
    checks++;
    if (head_seq !== exp_stream) begin
      failures++;
      $display("FAIL stall_head_seq got=%h exp=%h", head_seq, exp_stream);
    end
  endtask

  task automatic test_busy_start;
    run_load(1'b0, -1, 0, 15);
    checks++;
    if (sh_cnt != 36 || done_cnt != 1 || done_rel != 41) begin
      failures++;
      $display("FAIL busy_start got shifts=%0d dones=%0d at=%0d exp shifts=36 dones=1 at=41",
               sh_cnt, done_cnt, done_rel);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_load;
    int cnt, n;
    cnt = 0; n = 0;
    start = 1'b1; ven = 1'b0;
    tick();
    start = 1'b0;
    while (n < 200) begin
      valid = 1'b1; data = 8'h00;
      if (sen === 1'b1) cnt++;
      if (cnt == 20) break;
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, sen, ready, done} !== 4'b0 || cnt != 20) begin
      failures++;
      $display("FAIL mid_reset got busy=%b sen=%b ready=%b done=%b shifts=%0d exp all 0 shifts=20",
               busy, sen, ready, done, cnt);
    end
    rst = 1'b0; valid = 1'b0;
    tick();
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h09;
    run_load(1'b1, -1, 0, -1);
    checks++;
    if (verr !== 1'b0 || sh_cnt != 36) begin
      failures++;
      $display("FAIL mid_reset_verify got verr=%b shifts=%0d exp verr=0 shifts=36", verr, sh_cnt);
    end
  endtask

  task automatic test_small_chain;
    int acc, sh, dn, rel, fa, cyc, post;
    acc = 0; sh = 0; dn = 0; rel = -1; fa = -1; cyc = 0; post = 0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    while (cyc < 200 && post < 3) begin
      s_valid = 1'b1; s_data = 8'hC3;
      if (s_ready === 1'b1) begin
        if (fa < 0) fa = cyc;
        acc++;
      end
      if (s_sen === 1'b1) sh++;
      if (s_done === 1'b1) begin dn++; rel = cyc - fa; end
      tick();
      cyc++;
      if (dn > 0) post++;
    end
    s_valid = 1'b0;
    checks++;
    if (acc != 2 || sh != 16) begin
      failures++;
      $display("FAIL small_counts got accepts=%0d shifts=%0d exp accepts=2 shifts=16", acc, sh);
    end
    checks++;
    if (dn != 1 || rel != 18) begin
      failures++;
      $display("FAIL small_done got width=%0d at=%0d exp width=1 at=18", dn, rel);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ven = 1'b0; valid = 1'b0; data = 8'h00;
    s_start = 1'b0; s_ven = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_tail = 1'b0;
    test_reset();
    test_basic_load();
    test_verify();
    test_stall();
    test_busy_start();
    test_reset_mid_load();
    test_small_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
